// File: rtl/camera_capture_rgb332_if.sv
// camera_capture_rgb332 bus bundle: OV7670 byte bus in, frame-buffer write port
// and capture status out.
interface camera_capture_rgb332_if #(
    parameter int ADDR_W = 15
);
    logic              VSYNC;
    logic              HREF;
    logic [7:0]        DATA;
    logic              W_EN;
    logic [ADDR_W-1:0] W_ADDR;
    logic [7:0]        PIXEL_COLOR;
    logic [9:0]        X;
    logic [9:0]        Y;
    logic              FRAME_DONE;
    logic              LINE_ERR;

    modport master (
        input  VSYNC,
        input  HREF,
        input  DATA,
        output W_EN,
        output W_ADDR,
        output PIXEL_COLOR,
        output X,
        output Y,
        output FRAME_DONE,
        output LINE_ERR
    );

    modport slave (
        output VSYNC,
        output HREF,
        output DATA,
        input  W_EN,
        input  W_ADDR,
        input  PIXEL_COLOR,
        input  X,
        input  Y,
        input  FRAME_DONE,
        input  LINE_ERR
    );
endinterface

// File: rtl/camera_capture_rgb332.sv
// OV7670 capture: pairs RGB565 bytes into RGB332 pixels and writes them
// into the frame buffer at Y*SCREEN_WIDTH+X, windowed to the screen size.
module camera_capture_rgb332 #(
    parameter int SCREEN_WIDTH  = 176,
    parameter int SCREEN_HEIGHT = 144,
    parameter int ADDR_W        = 15
) (
    input logic                      CLK,
    input logic                      RESET_NEG,
    camera_capture_rgb332_if.master  bus
);

    typedef enum logic [1:0] {
        SYNC    = 2'd0,
        VBLANK  = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    localparam logic [9:0]        W_LIM  = 10'(SCREEN_WIDTH);
    localparam logic [9:0]        H_LIM  = 10'(SCREEN_HEIGHT);
    localparam logic [9:0]        X_MAX  = 10'h3FF;
    localparam logic [ADDR_W-1:0] W_STEP = ADDR_W'(SCREEN_WIDTH);

    state_t            state;
    logic              phase;
    logic              href_d;
    logic [5:0]        hi_byte;
    logic [ADDR_W-1:0] line_base;
    logic [9:0]        x_cnt;
    logic [9:0]        y_cnt;
    logic              w_en;
    logic [ADDR_W-1:0] w_addr;
    logic [7:0]        pix_q;
    logic              frame_done;
    logic              line_err;

    logic              in_window;
    logic              line_end;
    logic [7:0]        pixel;
    logic [9:0]        x_next;

    assign in_window = (x_cnt < W_LIM) && (y_cnt < H_LIM);
    assign line_end  = href_d && !bus.HREF;
    assign pixel     = {hi_byte, bus.DATA[4:3]};
    assign x_next    = (x_cnt == X_MAX) ? x_cnt : x_cnt + 10'd1;

    // Frame state machine, byte pairing, position counters and write port.
    always_ff @(posedge CLK or negedge RESET_NEG) begin
        if (!RESET_NEG) begin
            state      <= SYNC;
            phase      <= 1'b0;
            href_d     <= 1'b0;
            hi_byte    <= '0;
            line_base  <= '0;
            x_cnt      <= '0;
            y_cnt      <= '0;
            w_en       <= 1'b0;
            w_addr     <= '0;
            pix_q      <= '0;
            frame_done <= 1'b0;
            line_err   <= 1'b0;
        end else begin
            href_d     <= bus.HREF;
            w_en       <= 1'b0;
            frame_done <= 1'b0;
            unique case (state)
                SYNC: begin
                    // The frame in flight at reset is partial; wait it out.
                    if (bus.VSYNC) begin
                        state <= VBLANK;
                    end
                end
                VBLANK: begin
                    x_cnt     <= '0;
                    y_cnt     <= '0;
                    line_base <= '0;
                    phase     <= 1'b0;
                    line_err  <= 1'b0;
                    if (!bus.VSYNC) begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (bus.VSYNC) begin
                        // Half-assembled pixel is abandoned here.
                        frame_done <= 1'b1;
                        state      <= VBLANK;
                    end else if (bus.HREF) begin
                        if (!phase) begin
                            hi_byte <= {bus.DATA[7:5], bus.DATA[2:0]};
                            phase   <= 1'b1;
                        end else begin
                            if (in_window) begin
                                w_en   <= 1'b1;
                                pix_q  <= pixel;
                                w_addr <= line_base + ADDR_W'(x_cnt);
                            end
                            x_cnt <= x_next;
                            phase <= 1'b0;
                        end
                    end else if (line_end) begin
                        if (phase) begin
                            line_err <= 1'b1;
                        end
                        x_cnt <= '0;
                        phase <= 1'b0;
                        if (y_cnt < H_LIM) begin
                            y_cnt     <= y_cnt + 10'd1;
                            line_base <= line_base + W_STEP;
                        end
                    end
                end
                default: begin
                    state <= SYNC;
                end
            endcase
        end
    end

    assign bus.W_EN        = w_en;
    assign bus.W_ADDR      = w_addr;
    assign bus.PIXEL_COLOR = pix_q;
    assign bus.X           = x_cnt;
    assign bus.Y           = y_cnt;
    assign bus.FRAME_DONE  = frame_done;
    assign bus.LINE_ERR    = line_err;

endmodule
